// File: rtl/conv33_window_sink_if.sv
// conv33_window_sink_if: sum input stream and queued result output stream of the window sink.
interface conv33_window_sink_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/conv33_window_sink.sv
// conv33_window_sink: drops border-window stencil sums, scales and queues the rest with a frame tag.
module conv33_window_sink #(
  parameter int WIDTH = 16,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DEPTH = 4,
  parameter int SHIFT = 0
) (
  input  logic                clk,
  input  logic                reset,
  conv33_window_sink_if.slave bus,
  output logic                frame_done
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int AW = $clog2(DEPTH);
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [AW:0]      cnt, cnt_n;
  logic [AW-1:0]    wp, rp, rp1;
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             mem_last [DEPTH];
  logic             acc, push, pop, x_end, y_end, last;
  logic [WIDTH-1:0] sdata;
  assign bus.in_ready = cnt < (AW+1)'(DEPTH);
  assign acc   = bus.in_valid && bus.in_ready;
  assign x_end = x == XW'(IMG_W - 1);
  assign y_end = y == YW'(IMG_H - 1);
  assign last  = x_end && y_end;
  assign push  = acc && x >= XW'(2) && y >= YW'(2);
  assign pop   = bus.out_valid && bus.out_ready;
  assign sdata = bus.in_data >> SHIFT;
  assign rp1   = rp + 1'b1;
  assign cnt_n = cnt + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (acc) begin
      x <= x_end ? '0 : x + 1'b1;
      y <= x_end ? (y_end ? '0 : y + 1'b1) : y;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wp] <= sdata;
      mem_last[wp] <= last;
    end
  end
  // The output register is a copy of the head slot, refreshed only when the head changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      wp            <= '0;
      rp            <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      cnt           <= cnt_n;
      wp            <= wp + AW'(push);
      rp            <= rp + AW'(pop);
      bus.out_valid <= cnt_n != '0;
      frame_done    <= acc && last;
      if (pop && cnt > (AW+1)'(1)) begin
        bus.out_data <= mem_data[rp1];
        bus.out_last <= mem_last[rp1];
      end else if (push && cnt == (AW+1)'(pop)) begin
        bus.out_data <= sdata;
        bus.out_last <= last;
      end
    end
  end
endmodule
